// File: rtl/vend_machine_pkg.sv
// rtl/vend_machine_pkg.sv - shared coin/state types and coin helpers for the vending machine
// Contents:
//   coin_type    : accepted coin denominations (C1, C2, C5)
//   state_t      : controller states (IDLE, VEND, CHANGE)
//   coin_value   : face value of a coin
//   largest_coin : biggest denomination not exceeding an amount (greedy change)
package vend_machine_pkg;

   typedef enum logic [1:0] {
      C1 = 2'd0,
      C2 = 2'd1,
      C5 = 2'd2
   } coin_type;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam int COIN_VAL_W = 3;

   function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_type c);
      case (c)
         C1:      return 3'd1;
         C2:      return 3'd2;
         C5:      return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   // Greedy choice: with denominations 5/2/1 this always reaches zero exactly.
   function automatic coin_type largest_coin(input int unsigned amount);
      if (amount >= 5) return C5;
      if (amount >= 2) return C2;
      return C1;
   endfunction

endpackage

// File: rtl/vend_change_unit.sv
// rtl/vend_change_unit.sv - change coin selection and change handshake
// Ports:
//   active_i       : controller is in CHANGE
//   credit_i       : credit still owed to the customer
//   change_ready_i : consumer takes the offered coin this cycle
//   change_valid_o : a change coin is on offer
//   change_coin_o  : coin on offer (largest denomination <= credit)
//   take_o         : offered coin was taken this cycle
//   take_value_o   : value to deduct from credit when take_o is high
module vend_change_unit
   import vend_machine_pkg::*;
#(
   parameter int CREDIT_W = 6
) (
   input  logic                active_i,
   input  logic [CREDIT_W-1:0] credit_i,
   input  logic                change_ready_i,
   output logic                change_valid_o,
   output coin_type            change_coin_o,
   output logic                take_o,
   output logic [CREDIT_W-1:0] take_value_o
);

   // credit_i only moves when a coin is taken, so the offered coin stays
   // stable for as long as the consumer stalls.
   assign change_valid_o = active_i;
   assign change_coin_o  = largest_coin(32'(credit_i));
   assign take_o         = active_i & change_ready_i;
   assign take_value_o   = CREDIT_W'(coin_value(change_coin_o));

endmodule

// File: rtl/vend_machine.sv
// rtl/vend_machine.sv - coin-operated vending controller with stock counters and change return
// Ports:
//   clk, reset                            : clock, asynchronous active-low reset
//   coin_valid/coin/coin_ready            : coin offer handshake
//   coin_reject                           : pulse, accepted coin returned (credit would overflow)
//   select_valid/select_id                : product request
//   cancel                                : refund request
//   restock_valid/restock_id/restock_count: load a product stock counter
//   vend/vend_id                          : dispense pulse and product
//   sel_error                             : pulse, selection refused
//   change_valid/change_coin/change_ready : change handshake
//   credit, busy                          : current credit, controller not in IDLE
module vend_machine
   import vend_machine_pkg::*;
#(
   parameter int NUM_PRODUCTS = 4,
   parameter int CREDIT_W     = 6,
   parameter int MAX_CREDIT   = 20,
   parameter int STOCK_W      = 4,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
      {CREDIT_W'(3), CREDIT_W'(4), CREDIT_W'(5), CREDIT_W'(7)},
   localparam int ID_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_valid,
   input  coin_type            coin,
   output logic                coin_ready,
   output logic                coin_reject,
   input  logic                select_valid,
   input  logic [ID_W-1:0]     select_id,
   input  logic                cancel,
   input  logic                restock_valid,
   input  logic [ID_W-1:0]     restock_id,
   input  logic [STOCK_W-1:0]  restock_count,
   output logic                vend,
   output logic [ID_W-1:0]     vend_id,
   output logic                sel_error,
   output logic                change_valid,
   output coin_type            change_coin,
   input  logic                change_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam logic [ID_W:0] NUM_P = (ID_W + 1)'(NUM_PRODUCTS);

   // Price table unpacked from PRICES; the first listed price is product 0.
   logic [CREDIT_W-1:0] price_tbl [NUM_PRODUCTS];

   for (genvar p = 0; p < NUM_PRODUCTS; p++) begin : g_price
      localparam int PRICE = int'(PRICES[(NUM_PRODUCTS-1-p)*CREDIT_W +: CREDIT_W]);
      if (PRICE == 0 || PRICE > MAX_CREDIT) begin : g_bad_price
         $error("vend_machine: price of product %0d must be in 1..MAX_CREDIT", p);
      end
      assign price_tbl[p] = CREDIT_W'(PRICE);
   end

   if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_credit
      $error("vend_machine: MAX_CREDIT does not fit in CREDIT_W bits");
   end

   state_t              state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [STOCK_W-1:0]  stock_q [NUM_PRODUCTS];
   logic                vend_q;
   logic [ID_W-1:0]     vend_id_q;
   logic                sel_error_q;
   logic                coin_reject_q;

   logic                sel_id_ok;
   logic                sel_ok;
   logic [CREDIT_W-1:0] sel_price;
   logic [STOCK_W-1:0]  sel_stock;
   logic                restock_ok;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic                change_take;
   logic [CREDIT_W-1:0] change_value;

   assign coin_ready = (state_q == IDLE) && !cancel && !select_valid;

   assign sel_id_ok  = {1'b0, select_id} < NUM_P;
   assign sel_price  = sel_id_ok ? price_tbl[select_id] : '0;
   assign sel_stock  = sel_id_ok ? stock_q[select_id] : '0;
   assign sel_ok     = sel_id_ok && (credit_q >= sel_price) && (sel_stock != '0);
   assign restock_ok = {1'b0, restock_id} < NUM_P;

   // One extra bit so an overflowing sum is visible before the compare.
   assign coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin));
   assign coin_fits  = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);

   vend_change_unit #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .active_i       (state_q == CHANGE),
      .credit_i       (credit_q),
      .change_ready_i (change_ready),
      .change_valid_o (change_valid),
      .change_coin_o  (change_coin),
      .take_o         (change_take),
      .take_value_o   (change_value)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         credit_q      <= '0;
         vend_q        <= 1'b0;
         vend_id_q     <= '0;
         sel_error_q   <= 1'b0;
         coin_reject_q <= 1'b0;
         for (int p = 0; p < NUM_PRODUCTS; p++) begin
            stock_q[p] <= '0;
         end
      end else begin
         vend_q        <= 1'b0;
         sel_error_q   <= 1'b0;
         coin_reject_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // cancel > select > coin; losers are dropped this cycle
               if (cancel) begin
                  if (credit_q != '0) state_q <= CHANGE;
               end else if (select_valid) begin
                  if (sel_ok) begin
                     credit_q           <= credit_q - sel_price;
                     stock_q[select_id] <= sel_stock - STOCK_W'(1);
                     vend_q             <= 1'b1;
                     vend_id_q          <= select_id;
                     state_q            <= VEND;
                  end else begin
                     sel_error_q <= 1'b1;
                  end
               end else if (coin_valid) begin
                  if (coin_fits) credit_q <= coin_sum[CREDIT_W-1:0];
                  else           coin_reject_q <= 1'b1;
               end
            end
            VEND: begin
               state_q <= (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
               if (change_take) begin
                  credit_q <= credit_q - change_value;
                  if (credit_q == change_value) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Placed after the dispense decrement so a same-cycle load wins.
         if (restock_valid && restock_ok) begin
            stock_q[restock_id] <= restock_count;
         end
      end
   end

   assign vend        = vend_q;
   assign vend_id     = vend_id_q;
   assign sel_error   = sel_error_q;
   assign coin_reject = coin_reject_q;
   assign credit      = credit_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vend_machine.sv
// tb/tb_vend_machine.sv - scoreboard testbench for vend_machine with a transaction-level reference model
module tb_vend_machine;
   import vend_machine_pkg::*;

   localparam int NP       = 4;
   localparam int MAXC     = 20;
   localparam int EV_VEND  = 0;
   localparam int EV_SELER = 1;
   localparam int EV_REJ   = 2;
   localparam int EV_CHG   = 3;
   localparam int LIMIT    = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   coin_type   coin;
   logic       coin_ready;
   logic       coin_reject;
   logic       select_valid;
   logic [1:0] select_id;
   logic       cancel;
   logic       restock_valid;
   logic [1:0] restock_id;
   logic [3:0] restock_count;
   logic       vend;
   logic [1:0] vend_id;
   logic       sel_error;
   logic       change_valid;
   coin_type   change_coin;
   logic       change_ready;
   logic [5:0] credit;
   logic       busy;

   vend_machine dut (
      .clk           (clk),
      .reset         (reset),
      .coin_valid    (coin_valid),
      .coin          (coin),
      .coin_ready    (coin_ready),
      .coin_reject   (coin_reject),
      .select_valid  (select_valid),
      .select_id     (select_id),
      .cancel        (cancel),
      .restock_valid (restock_valid),
      .restock_id    (restock_id),
      .restock_count (restock_count),
      .vend          (vend),
      .vend_id       (vend_id),
      .sel_error     (sel_error),
      .change_valid  (change_valid),
      .change_coin   (change_coin),
      .change_ready  (change_ready),
      .credit        (credit),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       coin_v;
      coin_type coin;
      bit       sel_v;
      int       sid;
      bit       cancel;
      bit       rst_v;
      int       rid;
      int       rcnt;
   } op_t;

   typedef struct {
      int kind;
      int data;
   } ev_t;

   int  n_vec = 0;
   int  n_bad = 0;
   ev_t exp_q[$];
   int  m_credit;
   int  m_stock[NP];
   int  prices[NP] = '{3, 4, 5, 7};
   int  ready_mode = 2;   // 0 random, 1 held low, 2 held high

   function automatic int cval(input coin_type c);
      case (c)
         C1:      return 1;
         C2:      return 2;
         C5:      return 5;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic op_t nop();
      op_t o;
      o.coin_v = 0; o.coin = C1; o.sel_v = 0; o.sid = 0;
      o.cancel = 0; o.rst_v = 0; o.rid = 0; o.rcnt = 0;
      return o;
   endfunction

   function automatic op_t coin_op(input coin_type c);
      op_t o = nop();
      o.coin_v = 1; o.coin = c;
      return o;
   endfunction

   function automatic op_t sel_op(input int id);
      op_t o = nop();
      o.sel_v = 1; o.sid = id;
      return o;
   endfunction

   function automatic op_t cancel_op();
      op_t o = nop();
      o.cancel = 1;
      return o;
   endfunction

   function automatic op_t restock_op(input int id, input int cnt);
      op_t o = nop();
      o.rst_v = 1; o.rid = id; o.rcnt = cnt;
      return o;
   endfunction

   // Refund whatever is owed as a list of coins, biggest first.
   task automatic model_refund();
      int c;
      while (m_credit > 0) begin
         c = (m_credit >= 5) ? 5 : (m_credit >= 2) ? 2 : 1;
         exp_q.push_back('{EV_CHG, c});
         m_credit -= c;
      end
   endtask

   task automatic model_op(input op_t o);
      if (o.cancel) begin
         model_refund();
      end else if (o.sel_v) begin
         if (o.sid < NP && m_credit >= prices[o.sid] && m_stock[o.sid] > 0) begin
            m_credit -= prices[o.sid];
            m_stock[o.sid]--;
            exp_q.push_back('{EV_VEND, o.sid});
            model_refund();
         end else begin
            exp_q.push_back('{EV_SELER, 0});
         end
      end else if (o.coin_v) begin
         if (m_credit + cval(o.coin) <= MAXC) m_credit += cval(o.coin);
         else exp_q.push_back('{EV_REJ, 0});
      end
      if (o.rst_v && o.rid < NP) m_stock[o.rid] = o.rcnt;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_credit = 0;
      for (int i = 0; i < NP; i++) m_stock[i] = 0;
   endtask

   task automatic clear_inputs();
      coin_valid = 0; coin = C1; select_valid = 0; select_id = '0; cancel = 0;
      restock_valid = 0; restock_id = '0; restock_count = '0;
   endtask

   // Counts negedges with busy high; returns at a negedge with busy low.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      @(negedge clk);
      while (busy && cycles < LIMIT) begin
         cycles++;
         @(negedge clk);
      end
      if (busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL idle_timeout: busy still %0d after %0d cycles, required 0", busy, cycles);
      end
   endtask

   // Presents one operation for exactly one cycle while the DUT is idle.
   task automatic issue(input op_t o);
      model_op(o);
      @(posedge clk); #1;
      coin_valid    = o.coin_v;
      coin          = o.coin;
      select_valid  = o.sel_v;
      select_id     = 2'(o.sid);
      cancel        = o.cancel;
      restock_valid = o.rst_v;
      restock_id    = 2'(o.rid);
      restock_count = 4'(o.rcnt);
      @(negedge clk);
      chk("coin_ready", int'(coin_ready), int'(!o.cancel && !o.sel_v));
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic run_op(input op_t o, output int busy_cycles);
      int n;
      wait_idle(n);
      issue(o);
      wait_idle(busy_cycles);
      chk("credit_after_op", int'(credit), m_credit);
   endtask

   // Change handshake driver.
   initial begin
      change_ready = 0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       change_ready = 1'($urandom_range(0, 1));
            1:       change_ready = 0;
            default: change_ready = 1;
         endcase
      end
   end

   // Monitor: every DUT event is matched against the head of the expectation queue.
   bit       prev_stall = 0;
   coin_type prev_coin  = C1;
   int       prev_credit = 0;

   task automatic expect_ev(input int kind, input int data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d data %0d, required none", kind, data);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_data", data, e.data);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", int'(change_valid), 1);
               chk("stall_coin", cval(change_coin), cval(prev_coin));
               chk("stall_credit", int'(credit), prev_credit);
            end
            if (vend)        expect_ev(EV_VEND, int'(vend_id));
            if (sel_error)   expect_ev(EV_SELER, 0);
            if (coin_reject) expect_ev(EV_REJ, 0);
            if (change_valid && change_ready) expect_ev(EV_CHG, cval(change_coin));
            prev_stall  = change_valid && !change_ready;
            prev_coin   = change_coin;
            prev_credit = int'(credit);
         end
      end
   end

   initial begin
      int  n;
      op_t o;
      clear_inputs();
      model_reset();
      reset = 0;
      repeat (3) @(negedge clk);
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_vend", int'(vend), 0);
      chk("rst_vend_id", int'(vend_id), 0);
      chk("rst_sel_error", int'(sel_error), 0);
      chk("rst_coin_reject", int'(coin_reject), 0);
      chk("rst_change_valid", int'(change_valid), 0);
      chk("rst_coin_ready", int'(coin_ready), 1);
      reset = 1;

      // Buy product 1 with 7 credit: vend 1, change 2 then 1, stock 2 -> 1.
      run_op(restock_op(1, 2), n);
      run_op(coin_op(C2), n);
      run_op(coin_op(C5), n);
      run_op(sel_op(1), n);
      run_op(coin_op(C5), n);
      run_op(sel_op(1), n);             // last unit
      run_op(coin_op(C5), n);
      run_op(sel_op(1), n);             // out of stock
      run_op(cancel_op(), n);

      // Overflow at 18 credit, then a five-coin refund on consecutive cycles.
      run_op(coin_op(C5), n);
      run_op(coin_op(C5), n);
      run_op(coin_op(C5), n);
      run_op(coin_op(C2), n);
      run_op(coin_op(C1), n);
      run_op(coin_op(C5), n);
      chk("credit_held_18", int'(credit), 18);
      run_op(cancel_op(), n);
      chk("refund_cycles", n, 5);

      // Too little credit, then no stock.
      run_op(coin_op(C2), n);
      run_op(sel_op(0), n);
      chk("credit_kept_2", int'(credit), 2);
      run_op(coin_op(C5), n);
      run_op(coin_op(C2), n);
      run_op(coin_op(C1), n);
      run_op(sel_op(3), n);
      run_op(cancel_op(), n);

      // Consumer stalls for 5 cycles.
      run_op(coin_op(C5), n);
      ready_mode = 1;
      wait_idle(n);
      issue(cancel_op());
      repeat (5) @(negedge clk);
      chk("stall5_valid", int'(change_valid), 1);
      chk("stall5_coin", cval(change_coin), 5);
      chk("stall5_credit", int'(credit), 5);
      ready_mode = 2;
      wait_idle(n);
      chk("stall5_done_credit", int'(credit), 0);

      // Coin, select and cancel together: cancel wins.
      run_op(coin_op(C5), n);
      o = nop();
      o.coin_v = 1; o.coin = C2; o.sel_v = 1; o.sid = 0; o.cancel = 1;
      run_op(o, n);

      // Reset in the middle of a refund.
      ready_mode = 1;
      run_op(coin_op(C5), n);
      run_op(coin_op(C2), n);
      issue(cancel_op());
      @(negedge clk);
      chk("pre_reset_change_valid", int'(change_valid), 1);
      #2 reset = 0;
      #1;
      chk("mid_reset_change_valid", int'(change_valid), 0);
      chk("mid_reset_credit", int'(credit), 0);
      chk("mid_reset_busy", int'(busy), 0);
      model_reset();
      @(negedge clk);
      reset = 1;
      ready_mode = 2;

      // Restock on the same cycle as a dispense of that product.
      run_op(restock_op(2, 1), n);
      run_op(coin_op(C5), n);
      o = sel_op(2);
      o.rst_v = 1; o.rid = 2; o.rcnt = 1;
      run_op(o, n);
      run_op(coin_op(C5), n);
      run_op(sel_op(2), n);
      run_op(coin_op(C5), n);
      run_op(sel_op(2), n);
      run_op(cancel_op(), n);

      // Randomised traffic.
      ready_mode = 0;
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         o = nop();
         case (r)
            0, 1, 2, 3: begin o.coin_v = 1; o.coin = coin_type'($urandom_range(0, 2)); end
            4, 5:       begin o.sel_v = 1; o.sid = $urandom_range(0, NP - 1); end
            6:          o.cancel = 1;
            7:          begin o.rst_v = 1; o.rid = $urandom_range(0, NP - 1); o.rcnt = $urandom_range(0, 3); end
            default: begin
               o.coin_v = 1; o.coin = coin_type'($urandom_range(0, 2));
               o.sel_v  = 1'($urandom_range(0, 1));
               o.sid    = $urandom_range(0, NP - 1);
               o.cancel = 1'($urandom_range(0, 1));
            end
         endcase
         if ($urandom_range(0, 4) == 0) begin
            o.rst_v = 1; o.rid = $urandom_range(0, NP - 1); o.rcnt = $urandom_range(0, 3);
         end
         run_op(o, n);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
